alarm_clock_ctrl: RTL



---
 rtl/alarm_clock_pkg.sv | 20 ++
 rtl/alarm_clock_ctrl_tick_prescaler.sv | 46 ++++
 rtl/alarm_clock_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alarm_clock_pkg.sv
// ---------------------------------------------------------------------------
// alarm_clock_pkg
// Shared constants for the alarm clock controller: digit width and range,
// ring/snooze FSM state encoding, and the modulo-10 digit increment helper.
// ---------------------------------------------------------------------------
package alarm_clock_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RINGING = 2'd1;
   localparam logic [1:0] ST_SNOOZE  = 2'd2;

   // 9 wraps to 0; any out-of-range digit also lands on 0.
   function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
      return (d >= DIGIT_MAX) ? '0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/alarm_clock_ctrl_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to one time unit: counts 0..TICK_DIV-1 and pulses o_tick
// for one cycle after each wrap. i_hold parks the count at 0 and silences
// o_tick, so counting resumes from a full period when the hold is released.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   i_hold   level; freeze prescaler at 0
//   o_tick   one-cycle pulse per time unit
// ---------------------------------------------------------------------------
module tick_prescaler #(
   parameter int TICK_DIV = 50
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_hold,
   output logic o_tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (i_hold) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
         r_tick <= 1'b0;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/alarm_clock_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_clock_ctrl
// Sequencing controller for the single-digit alarm clock. Generates the time
// base, holds the current-time and alarm-time digits, selects the display
// source and runs the ring/snooze state machine that drives the buzzer.
//
// Build option: define ALARM_SNOOZE_EN to enable the snooze state; without
// it the i_snooze input is ignored.
//
// Ports:
//   i_clk           system clock
//   i_rst_n         synchronous active-low reset
//   i_set_time      level; time-set mode (has priority over alarm-set)
//   i_set_alarm     level; alarm-set mode
//   i_incr          button; one increment per rising edge
//   i_alarm_en      level; arms the alarm
//   i_alarm_off     level; stops ringing/snooze
//   i_snooze        level; snooze request while ringing
//   i_match_in      alarm==current compare result from the datapath
//   o_current_time  current digit 0..9
//   o_alarm_time    alarm digit 0..9
//   o_show_a        display alarm digit when 1 (registered)
//   o_buzzer        alarm sound drive
//   o_tick          one-cycle pulse per time unit
// ---------------------------------------------------------------------------
module alarm_clock_ctrl
   import alarm_clock_pkg::*;
#(
   parameter int TICK_DIV   = 50,
   parameter int RING_LEN   = 8,
   parameter int SNOOZE_LEN = 3
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_set_time,
   input  logic               i_set_alarm,
   input  logic               i_incr,
   input  logic               i_alarm_en,
   input  logic               i_alarm_off,
   input  logic               i_snooze,
   input  logic               i_match_in,
   output logic [DIGIT_W-1:0] o_current_time,
   output logic [DIGIT_W-1:0] o_alarm_time,
   output logic               o_show_a,
   output logic               o_buzzer,
   output logic               o_tick
);

   localparam int RW = $clog2(RING_LEN + 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_LEN - 1);
   localparam logic [RW-1:0] RING_MAX  = RW'(RING_LEN);

   // Reject out-of-range parameters at elaboration.
   if (TICK_DIV < 2 || RING_LEN < 1 || SNOOZE_LEN < 1) begin : g_bad_param
      $error("alarm_clock_ctrl: parameter out of range");
   end

   logic               w_tick;
   logic               w_incr_rise;
   logic               w_match_rise;
   logic               w_set_mode;
   logic               w_abort;
   logic               w_cur_step;

   logic [DIGIT_W-1:0] r_cur;
   logic [DIGIT_W-1:0] r_alarm;
   logic               r_show_a;
   logic               r_incr_q;
   logic               r_match_q;
   logic [1:0]         r_state;
   logic [RW-1:0]      r_ring_cnt;

`ifdef ALARM_SNOOZE_EN
   localparam int SW = $clog2(SNOOZE_LEN + 1);
   localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_LEN - 1);
   localparam logic [SW-1:0] SNZ_MAX  = SW'(SNOOZE_LEN);
   logic [SW-1:0]      r_snz_cnt;
`else
   logic               w_unused_snooze;
   assign w_unused_snooze = i_snooze;
`endif

   // Time base is frozen while the user is setting the time.
   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_hold  (i_set_time),
      .o_tick  (w_tick)
   );

   assign w_incr_rise  = i_incr & ~r_incr_q;
   assign w_match_rise = i_match_in & ~r_match_q;
   assign w_set_mode   = i_set_time | i_set_alarm;
   assign w_abort      = i_alarm_off | ~i_alarm_en | w_set_mode;
   // In time-set mode the button drives the digit; otherwise the time base does
   // (tick is already forced low while set_time is high).
   assign w_cur_step   = i_set_time ? w_incr_rise : w_tick;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cur    <= '0;
         r_alarm  <= '0;
         r_show_a <= 1'b0;
         r_incr_q <= 1'b0;
      end else begin
         r_incr_q <= i_incr;
         r_show_a <= ~i_set_time & i_set_alarm;
         if (w_cur_step) r_cur <= digit_inc(r_cur);
         if (~i_set_time && i_set_alarm && w_incr_rise) r_alarm <= digit_inc(r_alarm);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_ring_cnt <= '0;
         r_match_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         r_snz_cnt  <= '0;
`endif
      end else begin
         r_match_q <= i_match_in;
         case (r_state)
            ST_IDLE: begin
               // Only a fresh match edge arms a ring; a held match never re-rings.
               if (i_alarm_en && !w_set_mode && w_match_rise) begin
                  r_state    <= ST_RINGING;
                  r_ring_cnt <= '0;
               end
            end
            ST_RINGING: begin
               // alarm_off is part of w_abort, so it beats a simultaneous snooze.
               if (w_abort) r_state <= ST_IDLE;
`ifdef ALARM_SNOOZE_EN
               else if (i_snooze) begin
                  r_state   <= ST_SNOOZE;
                  r_snz_cnt <= '0;
               end
`endif
               else if (w_tick) begin
                  if (r_ring_cnt == RING_LAST) r_state <= ST_IDLE;
                  if (r_ring_cnt < RING_MAX) r_ring_cnt <= r_ring_cnt + RW'(1);
               end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
               if (w_abort) r_state <= ST_IDLE;
               else if (w_tick) begin
                  if (r_snz_cnt == SNZ_LAST) begin
                     r_state    <= ST_RINGING;
                     r_ring_cnt <= '0;
                  end else if (r_snz_cnt < SNZ_MAX) begin
                     r_snz_cnt <= r_snz_cnt + SW'(1);
                  end
               end
            end
`else
            // Snooze encoding is unreachable in this build; recover to IDLE.
            ST_SNOOZE: r_state <= ST_IDLE;
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_current_time = r_cur;
   assign o_alarm_time   = r_alarm;
   assign o_show_a       = r_show_a;
   assign o_buzzer       = (r_state == ST_RINGING);
   assign o_tick         = w_tick;

endmodule
